// File: rtl/nios_sys_key_pio.sv
// nios_sys_key_pio: Avalon-MM input PIO for push-buttons/switches.
// Two-flop synchroniser, per-bit counter debounce, sticky edge capture
// with write-one-to-clear, and a maskable level IRQ. Zero wait states,
// read data combinational from the address.
module nios_sys_key_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_RSVD = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_addr_e;

    reg_addr_e        w_addr;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic             w_wr_mask;
    logic             w_wr_edge;
    logic             w_unused_wdata;

    assign w_addr         = reg_addr_e'(address);
    assign w_unused_wdata = ^writedata;

    // Two-stage synchroniser for the asynchronous key inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= IDLE_VEC;
            r_sync2 <= IDLE_VEC;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign w_stable = r_sync2;
        end else begin : g_debounce
            localparam int unsigned    CW   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0]    r_cnt [WIDTH];
            logic [WIDTH-1:0] r_stable;

            // Per-bit debounce: accept a new level only after it holds for the full count
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stable <= IDLE_VEC;
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (r_sync2[i] == r_stable[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == TERM) begin
                            r_stable[i] <= r_sync2[i];
                            r_cnt[i]    <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end

            assign w_stable = r_stable;
        end
    endgenerate

    // Delayed copy of the debounced value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= IDLE_VEC;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    assign w_rise = w_stable & ~r_stable_d;
    assign w_fall = ~w_stable & r_stable_d;

    // Select which edge polarity feeds the capture register
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_rise;
            1:       w_edge = w_fall;
            default: w_edge = w_rise | w_fall;
        endcase
    end

    assign w_wr      = chipselect & ~write_n;
    assign w_wr_mask = w_wr && (w_addr == REG_MASK);
    assign w_wr_edge = w_wr && (w_addr == REG_EDGE);
    assign w_clr     = w_wr_edge ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
        end else if (w_wr_mask) begin
            r_irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge wins over a simultaneous clear of the same bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    // Combinational read mux, unused upper bits read as zero
    always_comb begin
        readdata = '0;
        case (w_addr)
            REG_DATA: readdata[WIDTH-1:0] = w_stable;
            REG_MASK: readdata[WIDTH-1:0] = r_irqmask;
            REG_EDGE: readdata[WIDTH-1:0] = r_edgecap;
            default:  readdata = '0;
        endcase
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios_sys_key_pio.sv
// Self-checking bench for nios_sys_key_pio: a debounced/falling-edge instance
// and a bypassed/any-edge instance sharing one Avalon bus.
module tb_nios_sys_key_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [3:0]  in_port_b;
    logic [31:0] readdata;
    logic [31:0] readdata_b;
    logic        irq;
    logic        irq_b;

    always #5 clk = ~clk;

    nios_sys_key_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    nios_sys_key_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
        .readdata(readdata_b), .irq(irq_b)
    );

    typedef struct {
        string       name;
        int unsigned sel;
        bit          is_irq;
        logic [31:0] exp;
    } sb_item_t;

    typedef struct {
        string       name;
        bit          do_wr;
        logic [1:0]  wr_addr;
        logic [31:0] wdata;
        logic [1:0]  rd_addr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    sb_item_t    sb_q[$];
    vec_t        vecs[9];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic score();
        sb_item_t    it;
        logic [31:0] act;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: no expected entry queued");
            return;
        end
        it = sb_q.pop_front();
        if (it.is_irq) act = (it.sel != 0) ? {31'b0, irq_b} : {31'b0, irq};
        else           act = (it.sel != 0) ? readdata_b : readdata;
        checks++;
        if (act !== it.exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
        end
    endtask

    task automatic expect_val(input string name, input int unsigned sel, input bit is_irq,
                              input logic [1:0] a, input logic [31:0] e);
        sb_item_t it;
        address   = a;
        it.name   = name;
        it.sel    = sel;
        it.is_irq = is_irq;
        it.exp    = e;
        sb_q.push_back(it);
        #1;
        score();
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] e);
        expect_val(name, 0, 1'b0, a, e);
    endtask

    task automatic rdb(input string name, input logic [1:0] a, input logic [31:0] e);
        expect_val(name, 1, 1'b0, a, e);
    endtask

    task automatic irqchk(input string name, input int unsigned sel, input logic e);
        expect_val(name, sel, 1'b1, 2'd0, {31'b0, e});
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // register-map vectors applied from the post-reset state
        vecs[0] = '{"map_data_reset",    1'b0, 2'd0, 32'h0,        2'd0, 32'h0000_000F, 1'b0};
        vecs[1] = '{"map_edge_reset",    1'b0, 2'd0, 32'h0,        2'd3, 32'h0000_0000, 1'b0};
        vecs[2] = '{"map_mask_reset",    1'b0, 2'd0, 32'h0,        2'd2, 32'h0000_0000, 1'b0};
        vecs[3] = '{"map_rsvd_read",     1'b0, 2'd0, 32'h0,        2'd1, 32'h0000_0000, 1'b0};
        vecs[4] = '{"map_rsvd_write",    1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000, 1'b0};
        vecs[5] = '{"map_data_write",    1'b1, 2'd0, 32'h0,        2'd0, 32'h0000_000F, 1'b0};
        vecs[6] = '{"map_mask_all",      1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_000F, 1'b0};
        vecs[7] = '{"map_edge_clr_idle", 1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000, 1'b0};
        vecs[8] = '{"map_mask_zero",     1'b1, 2'd2, 32'h0,        2'd2, 32'h0000_0000, 1'b0};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        in_port    = 4'hF;
        in_port_b  = 4'hF;
        tick(3);
        rd("rst_data_during", 2'd0, 32'hF);
        irqchk("rst_irq_during", 0, 1'b0);
        reset_n = 1'b1;
        tick(10);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wdata);
            rd(vecs[i].name, vecs[i].rd_addr, vecs[i].exp_rd);
            irqchk({vecs[i].name, "_irq"}, 0, vecs[i].exp_irq);
        end
        rdb("byp_data_reset", 2'd0, 32'hF);

        // bit0 falls: data after edge 6, capture after edge 7
        in_port = 4'hE;
        tick(5);
        rd("t2_data_edge5", 2'd0, 32'hF);
        tick(1);
        rd("t2_data_edge6", 2'd0, 32'hE);
        rd("t2_cap_edge6", 2'd3, 32'h0);
        tick(1);
        rd("t2_cap_edge7", 2'd3, 32'h1);
        irqchk("t2_irq_unmasked_off", 0, 1'b0);

        // mask in -> irq, clear -> irq drops
        bus_write(2'd2, 32'h1);
        irqchk("t3_irq_on", 0, 1'b1);
        bus_write(2'd3, 32'h1);
        irqchk("t3_irq_off", 0, 1'b0);
        rd("t3_cap_cleared", 2'd3, 32'h0);

        // 3-cycle glitch is rejected, long hold is accepted
        in_port = 4'hC;
        tick(3);
        in_port = 4'hE;
        tick(10);
        rd("t4_glitch_data", 2'd0, 32'hE);
        rd("t4_glitch_cap", 2'd3, 32'h0);
        in_port = 4'hC;
        tick(5);
        rd("t4_hold_data_edge5", 2'd0, 32'hE);
        tick(1);
        rd("t4_hold_data_edge6", 2'd0, 32'hC);
        tick(1);
        rd("t4_hold_cap", 2'd3, 32'h2);
        irqchk("t4_irq_bit1_masked", 0, 1'b0);

        // bit2 edge lands on the same clock as a clear of bit2
        in_port = 4'h8;
        tick(6);
        rd("t5_cap_pre", 2'd3, 32'h2);
        bus_write(2'd3, 32'h4);
        rd("t5_set_wins", 2'd3, 32'h6);
        bus_write(2'd3, 32'h2);
        rd("t5_clr_bit1_only", 2'd3, 32'h4);
        irqchk("t5_irq_bit2_masked", 0, 1'b0);
        bus_write(2'd2, 32'h4);
        irqchk("t5_irq_bit2_on", 0, 1'b1);
        bus_write(2'd2, 32'h0);
        irqchk("t5_irq_mask_off", 0, 1'b0);
        rd("t5_cap_kept", 2'd3, 32'h4);

        // reset in the middle of a pending bit3 debounce
        in_port = 4'h0;
        tick(3);
        rd("t6_data_midcount", 2'd0, 32'h8);
        reset_n = 1'b0;
        in_port = 4'hF;
        #1;
        rd("t6_data_in_reset", 2'd0, 32'hF);
        rd("t6_cap_in_reset", 2'd3, 32'h0);
        irqchk("t6_irq_in_reset", 0, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(12);
        rd("t6_data_after", 2'd0, 32'hF);
        rd("t6_cap_after", 2'd3, 32'h0);

        // bypassed debounce, any-edge capture
        in_port_b = 4'hE;
        tick(1);
        rdb("tb_data_edge1", 2'd0, 32'hF);
        tick(1);
        rdb("tb_data_edge2", 2'd0, 32'hE);
        rdb("tb_cap_edge2", 2'd3, 32'h0);
        tick(1);
        rdb("tb_fall_cap", 2'd3, 32'h1);
        bus_write(2'd3, 32'h1);
        rdb("tb_cap_clr", 2'd3, 32'h0);
        in_port_b = 4'hF;
        tick(2);
        rdb("tb_rise_data", 2'd0, 32'hF);
        rdb("tb_rise_cap_pre", 2'd3, 32'h0);
        tick(1);
        rdb("tb_rise_cap", 2'd3, 32'h1);
        bus_write(2'd2, 32'h1);
        irqchk("tb_irq_on", 1, 1'b1);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d entries not compared", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
